// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: buffer load/flush enables, load-use and branch
// hazard handling, variable-latency data memory handshake with timeout and debug stall counter.
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk_pipe_ctrl,
   input  logic             rst_n_pipe_ctrl,
   input  logic             MemRead_EX,
   input  logic [4:0]       rt_EX,
   input  logic [4:0]       rs_ID,
   input  logic [4:0]       rt_ID,
   input  logic             useRt_ID,
   input  logic             MemRead_MEM,
   input  logic             MemWrite_MEM,
   input  logic             branch_MEM,
   input  logic             dmem_ack,
   input  logic             stall_clr,
   output logic             pc_en,
   output logic             en_BF1,
   output logic             en_BF2,
   output logic             en_BF3,
   output logic             en_BF4,
   output logic             flush_BF1,
   output logic             flush_BF2,
   output logic             flush_BF3,
   output logic             flush_BF4,
   output logic             dmem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_wait_cnt, w_wait_cnt_nxt;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_mem_op, w_req, w_tmo_hit, w_done, w_adv, w_load_use;

   assign w_mem_op   = MemRead_MEM | MemWrite_MEM;
   assign w_req      = ((r_state == RUN) & w_mem_op) | (r_state == MEM_WAIT);
   assign w_tmo_hit  = (r_state == MEM_WAIT) & (r_wait_cnt == TMO);
   assign w_done     = dmem_ack | w_tmo_hit;
   assign w_adv      = ~w_req | w_done;
   assign w_load_use = MemRead_EX & (rt_EX != 5'd0) &
                       ((rt_EX == rs_ID) | (useRt_ID & (rt_EX == rt_ID)));

   // Everything is forced quiet while reset is held, so a stale access never leaks out.
   always_comb begin
      pc_en     = 1'b0;
      en_BF1    = 1'b0;
      en_BF2    = 1'b0;
      en_BF3    = 1'b0;
      en_BF4    = 1'b0;
      flush_BF1 = 1'b0;
      flush_BF2 = 1'b0;
      flush_BF3 = 1'b0;
      flush_BF4 = 1'b0;
      dmem_req  = 1'b0;
      if (rst_n_pipe_ctrl) begin
         dmem_req = w_req;
         if (!w_adv) begin
            en_BF4    = 1'b1;
            flush_BF4 = 1'b1;
         end else if (branch_MEM) begin
            {pc_en, en_BF1, en_BF2, en_BF3, en_BF4} = 5'b11111;
            {flush_BF1, flush_BF2, flush_BF3}       = 3'b111;
         end else if (w_load_use) begin
            {en_BF2, en_BF3, en_BF4} = 3'b111;
            flush_BF2                = 1'b1;
         end else begin
            {pc_en, en_BF1, en_BF2, en_BF3, en_BF4} = 5'b11111;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         RUN: begin
            if (w_mem_op && !dmem_ack) begin
               w_state_nxt    = MEM_WAIT;
               w_wait_cnt_nxt = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (w_done) begin
               w_state_nxt    = RUN;
               w_wait_cnt_nxt = 8'd0;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk_pipe_ctrl or negedge rst_n_pipe_ctrl) begin
      if (!rst_n_pipe_ctrl) begin
         r_state     <= RUN;
         r_wait_cnt  <= 8'd0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         // A late ack in the final wait cycle still counts as a good completion.
         if (w_tmo_hit && !dmem_ack)
            r_mem_err <= 1'b1;
         if (stall_clr)
            r_stall_cnt <= '0;
         else if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign mem_err   = r_mem_err;
   assign stall_cnt = r_stall_cnt;

endmodule
